// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port IDs and defaults.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arb_state_t;

   localparam logic PORT_CPU  = 1'b0;
   localparam logic PORT_HOST = 1'b1;

   localparam int DEF_ADDR_W    = 32;
   localparam int DEF_DATA_W    = 32;
   localparam int DEF_MAX_BURST = 16;

endpackage

// File: rtl/dmem_rd_tracker.sv
// Two-stage {valid, port} shift matching the RAM's registered-index plus one-cycle read latency;
// steers returning read data to the port that issued it.
module dmem_rd_tracker
   import dmem_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_rd_acc,
   input  logic              i_rd_port,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_rvalid0,
   output logic              o_rvalid1,
   output logic [DATA_W-1:0] o_rdata0,
   output logic [DATA_W-1:0] o_rdata1,
   output logic              o_busy
);

   logic [1:0]        r_vld;
   logic [1:0]        r_port;
   logic [DATA_W-1:0] r_hold0;
   logic [DATA_W-1:0] r_hold1;
   logic              w_rv0;
   logic              w_rv1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vld  <= '0;
         r_port <= '0;
      end else begin
         r_vld  <= {r_vld[0], i_rd_acc};
         r_port <= {r_port[0], i_rd_port};
      end
   end

   assign w_rv0 = r_vld[1] & (r_port[1] == PORT_CPU);
   assign w_rv1 = r_vld[1] & (r_port[1] == PORT_HOST);

   // RAM output is only meaningful in the return cycle, so keep a copy for the idle cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hold0 <= '0;
         r_hold1 <= '0;
      end else begin
         if (w_rv0) r_hold0 <= i_mem_rdata;
         if (w_rv1) r_hold1 <= i_mem_rdata;
      end
   end

   assign o_rvalid0 = w_rv0;
   assign o_rvalid1 = w_rv1;
   assign o_rdata0  = w_rv0 ? i_mem_rdata : r_hold0;
   assign o_rdata1  = w_rv1 ? i_mem_rdata : r_hold1;
   assign o_busy    = |r_vld;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the CPU (port 0) and host/DMA (port 1).
//   state | meaning
//   IDLE  | no owner; tie goes to the port other than the last granted one
//   LOCK0 | port 0 owns the RAM until it drops lock or the burst limit expires
//   LOCK1 | port 1 owns the RAM until it drops lock or the burst limit expires
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic              m0_lock,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic              m1_lock,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_index,
   output logic [DATA_W-1:0] mem_entry,
   input  logic [DATA_W-1:0] mem_entry_out,
   output logic              busy,
   output logic [31:0]       gnt_cnt0,
   output logic [31:0]       gnt_cnt1
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic              r_rr;
   logic              w_rr_nxt;
   logic [CNT_W-1:0]  r_burst_cnt;
   logic [CNT_W-1:0]  w_burst_nxt;
   logic [CNT_W-1:0]  w_burst_inc;
   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_acc;
   logic              w_sel;
   logic              w_sel_we;
   logic              w_sel_lock;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_index;
   logic [DATA_W-1:0] r_entry;
   logic [31:0]       r_cnt0;
   logic [31:0]       r_cnt1;
   logic              w_rd_busy;

   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      case (r_state)
         IDLE: begin
            if (m0_req && m1_req) begin
               w_gnt0 = (r_rr == PORT_HOST);
               w_gnt1 = (r_rr == PORT_CPU);
            end else begin
               w_gnt0 = m0_req;
               w_gnt1 = m1_req;
            end
         end
         LOCK0:   w_gnt0 = m0_req;
         LOCK1:   w_gnt1 = m1_req;
         default: ;
      endcase
   end

   assign w_acc       = w_gnt0 | w_gnt1;
   assign w_sel       = w_gnt1;
   assign w_sel_we    = w_sel ? m1_we    : m0_we;
   assign w_sel_lock  = w_sel ? m1_lock  : m0_lock;
   assign w_sel_addr  = w_sel ? m1_addr  : m0_addr;
   assign w_sel_wdata = w_sel ? m1_wdata : m0_wdata;
   assign w_burst_inc = r_burst_cnt + CNT_ONE;

   // The burst counter runs in every lock cycle, so an owner that stalls still burns its window.
   always_comb begin
      w_state_nxt = r_state;
      w_rr_nxt    = r_rr;
      w_burst_nxt = r_burst_cnt;
      if (w_acc) w_rr_nxt = w_sel;
      case (r_state)
         IDLE: begin
            w_burst_nxt = '0;
            if (w_acc && w_sel_lock && (MAX_BURST > 1)) begin
               w_state_nxt = w_sel ? LOCK1 : LOCK0;
               w_burst_nxt = CNT_ONE;
            end
         end
         LOCK0, LOCK1: begin
            w_burst_nxt = w_burst_inc;
            if (w_burst_inc == BURST_LAST) begin
               w_state_nxt = IDLE;
               w_rr_nxt    = (r_state == LOCK1);
               w_burst_nxt = '0;
            end else if (w_acc && !w_sel_lock) begin
               w_state_nxt = IDLE;
               w_burst_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_burst_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_rr        <= PORT_HOST;
         r_burst_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_rr        <= w_rr_nxt;
         r_burst_cnt <= w_burst_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_en <= 1'b0;
         r_index <= '0;
         r_entry <= '0;
         r_cnt0  <= '0;
         r_cnt1  <= '0;
      end else begin
         r_wr_en <= w_acc & w_sel_we;
         if (w_acc) begin
            r_index <= w_sel_addr;
            r_entry <= w_sel_wdata;
         end
         if (w_gnt0 && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + 32'd1;
         if (w_gnt1 && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + 32'd1;
      end
   end

   dmem_rd_tracker #(
      .DATA_W (DATA_W)
   ) u_rd_tracker (
      .clk         (clk),
      .rst         (rst),
      .i_rd_acc    (w_acc & ~w_sel_we),
      .i_rd_port   (w_sel),
      .i_mem_rdata (mem_entry_out),
      .o_rvalid0   (m0_rvalid),
      .o_rvalid1   (m1_rvalid),
      .o_rdata0    (m0_rdata),
      .o_rdata1    (m1_rdata),
      .o_busy      (w_rd_busy)
   );

   // Grants are combinational from req, so mask them while reset holds the registers.
   assign m0_gnt    = w_gnt0 & rst;
   assign m1_gnt    = w_gnt1 & rst;
   assign mem_wr_en = r_wr_en;
   assign mem_index = r_index;
   assign mem_entry = r_entry;
   assign gnt_cnt0  = r_cnt0;
   assign gnt_cnt1  = r_cnt1;
   assign busy      = (r_state != IDLE) | w_rd_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table of per-cycle requests and expected grants,
// a small RAM model, and a scoreboard of expected read returns.
module tb_dmem_arbiter;

   typedef struct {
      string       tag;
      logic        r0, w0, l0;
      logic [31:0] a0, d0;
      logic        r1, w1, l1;
      logic [31:0] a1, d1;
      logic        g0, g1;
      logic        pre_rst;
   } vec_t;

   typedef struct {
      logic        port;
      logic [31:0] data;
      int          due;
   } rd_exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic        mem_wr_en;
   logic [31:0] mem_index, mem_entry, mem_entry_out;
   logic        busy;
   logic [31:0] gnt_cnt0, gnt_cnt1;
   logic        ram_init;

   dmem_arbiter #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .MAX_BURST (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .m0_req        (m0_req),
      .m0_we         (m0_we),
      .m0_lock       (m0_lock),
      .m0_addr       (m0_addr),
      .m0_wdata      (m0_wdata),
      .m0_gnt        (m0_gnt),
      .m0_rvalid     (m0_rvalid),
      .m0_rdata      (m0_rdata),
      .m1_req        (m1_req),
      .m1_we         (m1_we),
      .m1_lock       (m1_lock),
      .m1_addr       (m1_addr),
      .m1_wdata      (m1_wdata),
      .m1_gnt        (m1_gnt),
      .m1_rvalid     (m1_rvalid),
      .m1_rdata      (m1_rdata),
      .mem_wr_en     (mem_wr_en),
      .mem_index     (mem_index),
      .mem_entry     (mem_entry),
      .mem_entry_out (mem_entry_out),
      .busy          (busy),
      .gnt_cnt0      (gnt_cnt0),
      .gnt_cnt1      (gnt_cnt1)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      return (i == 5) ? 32'h0000_1234 : (32'hA500_0000 + 32'(i));
   endfunction

   logic [31:0] ram [0:63];
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
      end else if (mem_wr_en) begin
         ram[mem_index[5:0]] <= mem_entry;
      end
      mem_entry_out <= ram[mem_index[5:0]];
   end

   int          n_err = 0;
   int          n_chk = 0;
   int          cyc   = 0;
   rd_exp_t     sb[$];
   vec_t        tbl[$];
   logic [31:0] shadow [0:63];
   logic        pv_acc, pv_we;
   logic [31:0] pv_addr, pv_data;
   logic [31:0] ec0, ec1, last0, last1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic vec_t mk(input string tag,
                               input logic r0, w0, l0, input int a0, input logic [31:0] d0,
                               input logic r1, w1, l1, input int a1, input logic [31:0] d1,
                               input logic g0, g1);
      vec_t v;
      v.tag = tag;
      v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
      v.g0 = g0; v.g1 = g1;
      v.pre_rst = 1'b0;
      return v;
   endfunction

   function automatic vec_t idle_v();
      return mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   task automatic drive(input vec_t v);
      m0_req = v.r0; m0_we = v.w0; m0_lock = v.l0; m0_addr = v.a0; m0_wdata = v.d0;
      m1_req = v.r1; m1_we = v.w1; m1_lock = v.l1; m1_addr = v.a1; m1_wdata = v.d1;
   endtask

   task automatic model_reset();
      sb.delete();
      pv_acc = 1'b0; pv_we = 1'b0; pv_addr = '0; pv_data = '0;
      ec0 = '0; ec1 = '0; last0 = '0; last1 = '0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_gnt0"},    m0_gnt,    0);
      chk({tag, "_gnt1"},    m1_gnt,    0);
      chk({tag, "_wr_en"},   mem_wr_en, 0);
      chk({tag, "_index"},   mem_index, 0);
      chk({tag, "_entry"},   mem_entry, 0);
      chk({tag, "_rvalid0"}, m0_rvalid, 0);
      chk({tag, "_rvalid1"}, m1_rvalid, 0);
      chk({tag, "_rdata0"},  m0_rdata,  0);
      chk({tag, "_rdata1"},  m1_rdata,  0);
      chk({tag, "_busy"},    busy,      0);
      chk({tag, "_cnt0"},    gnt_cnt0,  0);
      chk({tag, "_cnt1"},    gnt_cnt1,  0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      drive(idle_v());
      @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("rst");
      #1 rst = 1'b1;
      model_reset();
   endtask

   task automatic check_returns();
      rd_exp_t e;
      if (m0_rvalid || m1_rvalid) begin
         chk("rvalid_onehot", 32'(m0_rvalid & m1_rvalid), 0);
         if (sb.size() == 0) begin
            chk("rvalid_unexpected", {30'd0, m1_rvalid, m0_rvalid}, 0);
         end else begin
            e = sb.pop_front();
            chk("rd_port", m1_rvalid, e.port);
            chk("rd_data", m1_rvalid ? m1_rdata : m0_rdata, e.data);
            chk("rd_latency", cyc, e.due);
            if (e.port) last1 = e.data;
            else        last0 = e.data;
         end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
         chk("rvalid_missing", {30'd0, m1_rvalid, m0_rvalid}, sb[0].port ? 32'd2 : 32'd1);
         e = sb.pop_front();
      end
      if (!m0_rvalid) chk("rdata0_hold", m0_rdata, last0);
      if (!m1_rvalid) chk("rdata1_hold", m1_rdata, last1);
   endtask

   task automatic apply_vec(input vec_t v);
      rd_exp_t e;
      if (v.pre_rst) do_reset();
      @(posedge clk); #1;
      drive(v);
      @(negedge clk);
      cyc++;
      chk({v.tag, "_gnt0"}, m0_gnt, v.g0);
      chk({v.tag, "_gnt1"}, m1_gnt, v.g1);
      chk({v.tag, "_wr_en"}, mem_wr_en, pv_acc & pv_we);
      if (pv_acc) chk({v.tag, "_index"}, mem_index, pv_addr);
      if (pv_acc && pv_we) chk({v.tag, "_entry"}, mem_entry, pv_data);
      chk({v.tag, "_cnt0"}, gnt_cnt0, ec0);
      chk({v.tag, "_cnt1"}, gnt_cnt1, ec1);
      if (sb.size() > 0 && sb[0].due > cyc) chk({v.tag, "_busy"}, busy, 1);
      check_returns();
      pv_acc  = v.g0 | v.g1;
      pv_we   = v.g1 ? v.w1 : v.w0;
      pv_addr = v.g1 ? v.a1 : v.a0;
      pv_data = v.g1 ? v.d1 : v.d0;
      if (v.g0) ec0 = ec0 + 32'd1;
      if (v.g1) ec1 = ec1 + 32'd1;
      if (pv_acc) begin
         if (pv_we) begin
            shadow[pv_addr[5:0]] = pv_data;
         end else begin
            e.port = v.g1;
            e.data = shadow[pv_addr[5:0]];
            e.due  = cyc + 2;
            sb.push_back(e);
         end
      end
   endtask

   task automatic add_idle(input int n);
      for (int i = 0; i < n; i++) tbl.push_back(idle_v());
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      rst = 1'b0;
      ram_init = 1'b1;
      drive(idle_v());
      for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
      @(posedge clk);
      @(posedge clk); #1;
      ram_init = 1'b0;
      @(negedge clk);
      chk_reset_outputs("init");
      #1 rst = 1'b1;
      model_reset();

      // single CPU read of preloaded word 5
      tbl.push_back(mk("A_rd5", 1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 0));
      add_idle(3);

      // both ports reading every cycle from reset: strict alternation starting with port 0
      for (int k = 0; k < 8; k++) begin
         v = mk("B_alt", 1, 0, 0, 16 + (k + 1) / 2, 0, 1, 0, 0, 20 + k / 2, 0,
                (k % 2) == 0, (k % 2) == 1);
         if (k == 0) v.pre_rst = 1'b1;
         tbl.push_back(v);
      end
      add_idle(3);

      // host locked write burst 7..10 while CPU waits; then readback of 9
      tbl.push_back(mk("C_pre", 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk("C_lockwr", 1, 0, 0, 12, 0, 1, 1, i < 3, 7 + i, 32'h0000_DEAD, 0, 1));
      tbl.push_back(mk("C_cpu", 1, 0, 0, 12, 0, 0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk("C_rb9", 1, 0, 0, 9, 0, 0, 0, 0, 0, 0, 1, 0));
      add_idle(3);

      // host never drops lock: forced release after 16 owned cycles
      for (int c = 0; c < 16; c++)
         tbl.push_back(mk("D_burst", 1, 0, 0, 2, 0, 1, 1, 1, 40 + c, 32'hB000_0000 + 32'(c), 0, 1));
      tbl.push_back(mk("D_release", 1, 0, 0, 2, 0, 1, 1, 1, 56, 32'hB000_0010, 1, 0));
      tbl.push_back(mk("D_regain",  1, 0, 0, 3, 0, 1, 1, 1, 56, 32'hB000_0010, 0, 1));
      tbl.push_back(mk("D_unlock",  1, 0, 0, 3, 0, 1, 1, 0, 57, 32'hB000_0011, 0, 1));
      tbl.push_back(mk("D_cpu",     1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0));
      add_idle(3);

      // CPU lock with 3 idle cycles inside; idle cycles still count toward the limit
      tbl.push_back(mk("E_lock", 1, 0, 1, 20, 0, 0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk("E_own",  1, 0, 1, 21, 0, 1, 1, 0, 60, 32'h0000_C0DE, 1, 0));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk("E_gap", 0, 0, 0, 0, 0, 1, 1, 0, 60, 32'h0000_C0DE, 0, 0));
      for (int j = 0; j < 11; j++)
         tbl.push_back(mk("E_own", 1, 0, 1, 22 + j, 0, 1, 1, 0, 60, 32'h0000_C0DE, 1, 0));
      tbl.push_back(mk("E_release", 1, 0, 1, 33, 0, 1, 1, 0, 60, 32'h0000_C0DE, 0, 1));
      tbl.push_back(mk("E_relock",  1, 0, 1, 33, 0, 0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk("E_unlock",  1, 0, 0, 34, 0, 0, 0, 0, 0, 0, 1, 0));
      add_idle(3);
      tbl.push_back(mk("E_rb60", 0, 0, 0, 0, 0, 1, 0, 0, 60, 0, 0, 1));
      add_idle(3);

      foreach (tbl[i]) apply_vec(tbl[i]);

      // reset asserted the cycle after a CPU read is accepted
      apply_vec(mk("F_rd", 1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 0));
      @(posedge clk); #1;
      rst = 1'b0;
      drive(mk("F_rst", 1, 0, 0, 5, 0, 1, 1, 0, 3, 32'h0000_0055, 0, 0));
      @(negedge clk);
      chk_reset_outputs("F_midrst");
      #1;
      drive(idle_v());
      rst = 1'b1;
      model_reset();
      apply_vec(mk("F_tie", 1, 0, 0, 6, 0, 1, 0, 0, 7, 0, 1, 0));
      apply_vec(mk("F_p1",  0, 0, 0, 0, 0, 1, 0, 0, 7, 0, 0, 1));
      for (int i = 0; i < 4; i++) apply_vec(idle_v());
      chk("sb_drained", 32'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter that shares the single-port data-memory RAM between the multicycle CPU (port 0) and a host/DMA loader (port 1) that preloads and drains matrix data. It accepts at most one beat per clock using a valid/grant handshake with round-robin fairness and optional bounded bursts. It drives registered RAM controls and routes the RAM's one-cycle-latency read data back to the issuing port.

Parameters:
ADDR_W, 32, word index width presented to RAM `index`
DATA_W, 32, data width
MAX_BURST, 16, maximum beats, including idle lock cycles, one port may hold a lock

Ports:
clk  in  1  system clock, same clock as the data-memory RAM
rst  in  1  asynchronous, active-low reset
m0_req  in  1  port 0 (CPU) beat request
m0_we  in  1  1 = write, 0 = read
m0_lock  in  1  request to keep ownership after this beat
m0_addr  in  ADDR_W  word index
m0_wdata  in  DATA_W  write data
m0_gnt  out  1  beat accepted this cycle (combinational)
m0_rvalid  out  1  read data valid pulse
m0_rdata  out  DATA_W  read data
m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as port 0, for port 1 (host/DMA)
mem_wr_en  out  1  RAM write enable, registered
mem_index  out  ADDR_W  RAM index, registered
mem_entry  out  DATA_W  RAM write data, registered
mem_entry_out  in  DATA_W  RAM read data, valid the cycle after index is presented
busy  out  1  state != IDLE or any read in flight
gnt_cnt0, gnt_cnt1  out  32  accepted-beat counters, saturating at 0xFFFF_FFFF

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, rr pointer=1 so port 0 wins the first tie.
  - burst counter=0; read-tag pipeline cleared.
  - All outputs 0, including mem_wr_en.
- Handshake:
  - A beat transfers in any cycle where mX_req=1 and mX_gnt=1.
  - Requester holds req/we/addr/wdata stable until it sees gnt.
  - gnt is a combinational function of req and registered state.
  - At most one gnt is high per cycle.
- FSM, states IDLE, LOCK0, LOCK1:
  - IDLE, both ports requesting: grant the port != rr pointer.
  - IDLE, one port requesting: grant that port.
  - On any accepted beat, rr pointer := granted port.
  - Accepted beat with lock=1 from IDLE -> LOCKn, burst counter := 1.
  - LOCKn: only port n may be granted; the other port's gnt=0.
  - LOCKn: burst counter increments every cycle, whether or not port n requests.
  - LOCKn, accepted beat with lock=0 -> IDLE.
  - LOCKn, burst counter reaches MAX_BURST -> IDLE, with rr pointer := n so the other port wins the next tie.
  - Forced release applies even if the final beat carried lock=1.
- Issue timing:
  - Beat accepted in cycle t: mem_index, mem_entry and mem_wr_en (=we) are valid in cycle t+1.
  - mem_wr_en is a one-cycle pulse and is 0 in any cycle with no accepted beat the previous cycle.
- Read return:
  - Read accepted in cycle t: mX_rvalid=1 in cycle t+2 with mX_rdata=mem_entry_out.
  - Writes produce no rvalid.
  - Back-to-back reads return in order, one per cycle.
  - rdata holds its last value when rvalid=0.
- Counters: gnt_cntX increments on each accepted beat of port X; it holds at its maximum value.
- Reset mid-operation: in-flight reads are dropped with no rvalid, a pending write is suppressed, and the lock is released.
- Simultaneous events: a lock release beat and a request from the other port in the same cycle -> the other port can win the following cycle at the earliest.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state encoding (IDLE/LOCK0/LOCK1);
  - port IDs (PORT_CPU=0, PORT_HOST=1);
  - default widths and MAX_BURST.
- Sub-module dmem_rd_tracker is a 2-stage shift of {valid, port_id} that produces the per-port rvalid and steers rdata.

Test Plan:
- RAM word 5 preloaded with 0x0000_1234; port 0 reads addr 5 -> m0_gnt same cycle, mem_index=5 next cycle, m0_rvalid with rdata 0x0000_1234 two cycles after accept; m1_rvalid stays 0; gnt_cnt0=1.
- Both ports request reads every cycle, lock=0, for 8 cycles from reset -> grants alternate 0,1,0,1,...; gnt_cnt0=gnt_cnt1=4; rvalid alternates with correct data.
- Port 1 writes 0xDEAD to addrs 7..10 with lock=1,1,1,0 while port 0 requests -> m0_gnt=0 for 4 cycles, mem_wr_en pulses at 7..10, port 0 granted in cycle 5; readback of addr 9 returns 0xDEAD.
- Port 1 holds lock=1 continuously with MAX_BURST=16 while port 0 requests -> forced release after 16 cycles, port 0 granted next cycle, port 1 regains ownership afterwards.
- Port 0 takes a lock, then drops req for 3 cycles inside the lock -> port 1 stalled during those cycles; the idle cycles count toward MAX_BURST.
- rst pulsed low the cycle after a port 0 read accept -> no m0_rvalid, all outputs 0 during reset; after release a tie grants port 0 first.
